// File: rtl/oflow_iou_best_match.sv
// ---------------------------------------------------------------------------
// oflow_iou_best_match
//
// Purpose:
//   Sits behind the per-pair IoU-cost stage. For one current-frame object it
//   takes a stream of IoU-cost values (1 - I/U, so lower is a better overlap),
//   one per history-frame candidate. It keeps the minimum cost and the index
//   of that candidate, applies a match threshold, and hands one result per
//   object to the object-ID assignment logic over a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset_N      asynchronous active-low reset
//   start        one-cycle pulse that opens a new object search (IDLE only)
//   threshold    largest cost accepted as a match, captured when start is taken
//   iou_valid    iou / iou_id / iou_last carry a candidate this cycle
//   iou_ready    block accepts a candidate beat this cycle (COLLECT only)
//   iou          IoU-cost of the candidate
//   iou_id       history index of the candidate
//   iou_last     final candidate for this object
//   match_valid  result is valid (DONE state)
//   match_ready  consumer accepts the result
//   match_found  at least one candidate seen and best cost <= threshold
//   match_id     index of the best candidate
//   match_iou    best (minimum) cost
//   match_count  number of candidates accepted
//   overflow     MAX_HISTORY beats arrived without iou_last
//   busy         search in progress or result pending
// ---------------------------------------------------------------------------
module oflow_iou_best_match #(
    parameter int MAX_HISTORY = 32,
    parameter int ID_W        = 5,
    parameter int IOU_W       = 22
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic             start,
    input  logic [IOU_W-1:0] threshold,
    input  logic             iou_valid,
    output logic             iou_ready,
    input  logic [IOU_W-1:0] iou,
    input  logic [ID_W-1:0]  iou_id,
    input  logic             iou_last,
    output logic             match_valid,
    input  logic             match_ready,
    output logic             match_found,
    output logic [ID_W-1:0]  match_id,
    output logic [IOU_W-1:0] match_iou,
    output logic [ID_W:0]    match_count,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Starting value of the running minimum. An all-ones cost never beats
    // it, so such a candidate only counts toward match_count.
    localparam logic [IOU_W-1:0] COST_INIT   = '1;
    localparam logic [ID_W:0]    COUNT_LIMIT = (ID_W + 1)'(MAX_HISTORY);

    state_t            state;
    state_t            state_nxt;
    logic [IOU_W-1:0]  best_cost;
    logic [ID_W-1:0]   best_id;
    logic [ID_W:0]     count;
    logic              overflow_r;
    logic [IOU_W-1:0]  thr_reg;

    logic              beat_accept;
    logic [ID_W:0]     count_inc;
    logic              hit_limit;

    assign beat_accept = (state == COLLECT) && iou_valid;
    assign count_inc   = count + 1'b1;
    // True when the beat being accepted is the MAX_HISTORY-th one.
    assign hit_limit   = (count_inc == COUNT_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. start is only honoured in IDLE, so a start that lands
    // on the DONE handshake edge is dropped and must be re-issued.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (beat_accept && (iou_last || hit_limit)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (match_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Search datapath. Strict less-than keeps the earlier candidate on a tie.
    // Overflow is flagged only when the limit is reached without iou_last.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            best_cost  <= COST_INIT;
            best_id    <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
            thr_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        best_cost  <= COST_INIT;
                        best_id    <= '0;
                        count      <= '0;
                        overflow_r <= 1'b0;
                        thr_reg    <= threshold;
                    end
                end
                COLLECT: begin
                    if (beat_accept) begin
                        count <= count_inc;
                        if (iou < best_cost) begin
                            best_cost <= iou;
                            best_id   <= iou_id;
                        end
                        if (!iou_last && hit_limit) begin
                            overflow_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are pure functions of registered state, so they stay stable
    // for the whole DONE stall.
    assign iou_ready   = (state == COLLECT);
    assign match_valid = (state == DONE);
    assign busy        = (state != IDLE);
    assign match_found = (count != '0) && (best_cost <= thr_reg);
    assign match_id    = best_id;
    assign match_iou   = best_cost;
    assign match_count = count;
    assign overflow    = overflow_r;

endmodule
